mod_muxout: RTL and testbench

Output-side collector of the AES256 core, the counterpart of the input demultiplexer on the master bus. It accepts one ciphertext block from the encrypter, buffers it, and returns it to the master as a sequence of 32-bit words on master read requests. It also answers control-flag reads from regCTRL. It is the only path by which encrypted data and control status leave the core.

---
 rtl/mod_muxout_if.sv | 28 ++
 rtl/mod_muxout.sv | 118 +++++++++++
 tb/tb_mod_muxout.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mod_muxout_if.sv
// Master-side bus between the ciphertext collector, the encrypter and the bus master.
// Carries read requests/responses, regCTRL flags and the ciphertext block handoff.
interface mod_muxout_if #(
  parameter int unsigned N      = 16,
  parameter int unsigned WL     = 32,
  parameter int unsigned nFlags = 32
);
  logic                   rd_en;
  logic                   addr;
  logic [nFlags-1:0]      flags_in;
  logic                   ct_valid;
  logic [N-1:0][7:0]      ct_data;
  logic                   ct_ready;
  logic [WL-1:0]          outp;
  logic                   outp_valid;
  logic                   rd_err;
  logic                   blk_rdy;

  modport master (
    output rd_en, addr, flags_in, ct_valid, ct_data,
    input  ct_ready, outp, outp_valid, rd_err, blk_rdy
  );

  modport slave (
    input  rd_en, addr, flags_in, ct_valid, ct_data,
    output ct_ready, outp, outp_valid, rd_err, blk_rdy
  );
endinterface

// File: rtl/mod_muxout.sv
// Ciphertext output collector: buffers one block and returns it word by word on master reads.
// Optional feature macro MUXOUT_FLAGS_READ_EN enables regCTRL flag reads at addr=0.
module mod_muxout #(
  parameter int unsigned N      = 16,
  parameter int unsigned WL     = 32,
  parameter int unsigned nFlags = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mod_muxout_if.slave    bus
);
  localparam int unsigned NW = (N * 8) / WL;
  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state_q, state_nxt;
  logic [CW-1:0]          wcnt_q, wcnt_nxt;
  logic [N-1:0][7:0]      buf_q;
  logic                   load_c;
  logic [WL-1:0]          outp_q, outp_nxt;
  logic                   valid_q, valid_nxt;
  logic                   err_q, err_nxt;
  logic [NW-1:0][WL-1:0]  words_c;

  // Byte 0 sits in the LSBs, so the packed buffer already is the word array.
  assign words_c = buf_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state, word counter, read response
  always_comb begin
    state_nxt = state_q;
    wcnt_nxt  = wcnt_q;
    load_c    = 1'b0;
    outp_nxt  = outp_q;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;

    case (state_q)
      EMPTY: begin
        if (bus.ct_valid) begin
          load_c    = 1'b1;
          wcnt_nxt  = '0;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.rd_en && bus.addr) begin
          if (wcnt_q == CW'(NW - 1)) begin
            wcnt_nxt  = '0;
            state_nxt = EMPTY;
          end else begin
            wcnt_nxt = wcnt_q + CW'(1);
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase

    if (bus.rd_en) begin
      valid_nxt = 1'b1;
      if (bus.addr) begin
        if (state_q == HOLD) begin
          outp_nxt = words_c[wcnt_q];
        end else begin
          outp_nxt = '0;
          err_nxt  = 1'b1;
        end
      end else begin
`ifdef MUXOUT_FLAGS_READ_EN
        outp_nxt = WL'(bus.flags_in);
`else
        outp_nxt = '0;
        err_nxt  = 1'b1;
`endif
      end
    end
  end

`ifndef MUXOUT_FLAGS_READ_EN
  // Flags port kept for a uniform interface; intentionally not consumed.
  logic unused_flags;
  assign unused_flags = ^bus.flags_in;
`endif

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      buf_q   <= '0;
      outp_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_nxt;
      outp_q  <= outp_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
      if (load_c) begin
        buf_q <= bus.ct_data;
      end
    end
  end

  assign bus.ct_ready   = (state_q == EMPTY);
  assign bus.blk_rdy    = (state_q == HOLD);
  assign bus.outp       = outp_q;
  assign bus.outp_valid = valid_q;
  assign bus.rd_err     = err_q;
endmodule

// File: tb/tb_mod_muxout.sv
// Directed self-checking bench for mod_muxout: drain, empty read, flags read,
// back-to-back reads with a held block, and reset mid-block.
module tb_mod_muxout;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mod_muxout_if #(.N(16), .WL(32), .nFlags(32)) bus ();

  mod_muxout #(.N(16), .WL(32), .nFlags(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic a);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic load_block(input logic [7:0] base, input logic all_ones);
    for (int i = 0; i < 16; i++) bus.ct_data[i] = all_ones ? 8'hFF : 8'(base + 8'(i));
    bus.ct_valid = 1'b1;
    tick();
    bus.ct_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.ct_ready !== 1'b1) begin errors++; $display("FAIL reset_ct_ready got %b exp 1", bus.ct_ready); end
    checks++; if (bus.blk_rdy !== 1'b0) begin errors++; $display("FAIL reset_blk_rdy got %b exp 0", bus.blk_rdy); end
    checks++; if (bus.outp !== 32'h0) begin errors++; $display("FAIL reset_outp got %h exp 0", bus.outp); end
    checks++; if (bus.outp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.outp_valid); end
    checks++; if (bus.rd_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.rd_err); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_drain();
    logic [31:0] exp_w [4];
    exp_w = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    load_block(8'h00, 1'b0);
    checks++; if (bus.blk_rdy !== 1'b1 || bus.ct_ready !== 1'b0) begin errors++; $display("FAIL drain_hold blk_rdy=%b ct_ready=%b exp 1/0", bus.blk_rdy, bus.ct_ready); end
    for (int k = 0; k < 4; k++) begin
      rd(1'b1);
      checks++; if (bus.outp !== exp_w[k] || bus.outp_valid !== 1'b1 || bus.rd_err !== 1'b0) begin
        errors++; $display("FAIL drain_word%0d got %h v=%b e=%b exp %h v=1 e=0", k, bus.outp, bus.outp_valid, bus.rd_err, exp_w[k]);
      end
    end
    checks++; if (bus.ct_ready !== 1'b1 || bus.blk_rdy !== 1'b0) begin errors++; $display("FAIL drain_empty ct_ready=%b blk_rdy=%b exp 1/0", bus.ct_ready, bus.blk_rdy); end
    tick();
    checks++; if (bus.outp_valid !== 1'b0 || bus.outp !== 32'h0F0E0D0C) begin errors++; $display("FAIL idle_hold v=%b outp=%h exp v=0 outp=0f0e0d0c", bus.outp_valid, bus.outp); end
  endtask

  task automatic test_empty_read();
    rd(1'b1);
    checks++; if (bus.outp !== 32'h0 || bus.outp_valid !== 1'b1 || bus.rd_err !== 1'b1) begin
      errors++; $display("FAIL empty_read got %h v=%b e=%b exp 0 v=1 e=1", bus.outp, bus.outp_valid, bus.rd_err);
    end
    checks++; if (bus.ct_ready !== 1'b1 || bus.blk_rdy !== 1'b0) begin errors++; $display("FAIL empty_state ct_ready=%b blk_rdy=%b exp 1/0", bus.ct_ready, bus.blk_rdy); end
  endtask

  task automatic test_flags();
    logic [31:0] exp_f;
    logic        exp_e;
`ifdef MUXOUT_FLAGS_READ_EN
    exp_f = 32'hA5A50001; exp_e = 1'b0;
`else
    exp_f = 32'h0;        exp_e = 1'b1;
`endif
    load_block(8'h00, 1'b0);
    rd(1'b1);
    rd(1'b1);
    bus.flags_in = 32'hA5A5_0001;
    rd(1'b0);
    bus.flags_in = 32'h0;
    checks++; if (bus.outp !== exp_f || bus.outp_valid !== 1'b1 || bus.rd_err !== exp_e) begin
      errors++; $display("FAIL flags_read got %h v=%b e=%b exp %h v=1 e=%b", bus.outp, bus.outp_valid, bus.rd_err, exp_f, exp_e);
    end
    checks++; if (bus.blk_rdy !== 1'b1) begin errors++; $display("FAIL flags_keeps_hold blk_rdy=%b exp 1", bus.blk_rdy); end
    rd(1'b1);
    checks++; if (bus.outp !== 32'h0B0A0908 || bus.rd_err !== 1'b0) begin errors++; $display("FAIL flags_then_word2 got %h e=%b exp 0b0a0908 e=0", bus.outp, bus.rd_err); end
    rd(1'b1);
    checks++; if (bus.outp !== 32'h0F0E0D0C || bus.ct_ready !== 1'b1) begin errors++; $display("FAIL flags_word3 got %h rdy=%b exp 0f0e0d0c rdy=1", bus.outp, bus.ct_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    exp_w = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    for (int i = 0; i < 16; i++) bus.ct_data[i] = 8'(8'h10 + 8'(i));
    bus.ct_valid = 1'b1;
    tick();
    bus.ct_data = '1;
    bus.rd_en = 1'b1;
    bus.addr  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.outp !== exp_w[k] || bus.outp_valid !== 1'b1 || bus.rd_err !== 1'b0) begin
        errors++; $display("FAIL b2b_word%0d got %h v=%b e=%b exp %h v=1 e=0", k, bus.outp, bus.outp_valid, bus.rd_err, exp_w[k]);
      end
    end
    bus.rd_en = 1'b0;
    checks++; if (bus.ct_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_last got %b exp 1", bus.ct_ready); end
    tick();
    bus.ct_valid = 1'b0;
    checks++; if (bus.blk_rdy !== 1'b1) begin errors++; $display("FAIL b2b_second_capture blk_rdy=%b exp 1", bus.blk_rdy); end
    for (int k = 0; k < 4; k++) begin
      rd(1'b1);
      checks++; if (bus.outp !== 32'hFFFFFFFF || bus.rd_err !== 1'b0) begin errors++; $display("FAIL b2b_ff_word%0d got %h e=%b exp ffffffff e=0", k, bus.outp, bus.rd_err); end
    end
  endtask

  task automatic test_reset_mid();
    load_block(8'h40, 1'b0);
    rd(1'b1);
    checks++; if (bus.outp !== 32'h43424140) begin errors++; $display("FAIL mid_word0 got %h exp 43424140", bus.outp); end
    rst_n = 1'b0;
    #3;
    checks++; if (bus.ct_ready !== 1'b1 || bus.blk_rdy !== 1'b0 || bus.outp !== 32'h0) begin
      errors++; $display("FAIL mid_in_reset rdy=%b blk=%b outp=%h exp 1/0/0", bus.ct_ready, bus.blk_rdy, bus.outp);
    end
    tick();
    rst_n = 1'b1;
    tick();
    rd(1'b1);
    checks++; if (bus.rd_err !== 1'b1 || bus.outp !== 32'h0 || bus.ct_ready !== 1'b1) begin
      errors++; $display("FAIL mid_after_reset e=%b outp=%h rdy=%b exp e=1 outp=0 rdy=1", bus.rd_err, bus.outp, bus.ct_ready);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    bus.rd_en    = 1'b0;
    bus.addr     = 1'b0;
    bus.flags_in = '0;
    bus.ct_valid = 1'b0;
    bus.ct_data  = '0;
    rst_n        = 1'b1;
    #2;
    test_reset();
    test_drain();
    test_empty_read();
    test_flags();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
